// File: rtl/proj_extender_sched.sv
// rtl/proj_extender_sched.sv - round-robin scheduler sharing one fragment extender between requesters
module proj_extender_sched #(
    parameter int NUM_REQ       = 2,
    parameter int FRAG_LEN_BITS = 8,
    parameter int FRAG_PART     = 4,
    parameter int INDICES_COUNT = 4,
    parameter int INDICE_LEN    = 3,
    localparam int FRAG_PARTS_COUNT = FRAG_LEN_BITS / FRAG_PART,
    localparam int PART_BITS = (FRAG_PARTS_COUNT > 1) ? $clog2(FRAG_PARTS_COUNT) : 1,
    localparam int IDX_BITS  = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1,
    localparam int REQ_BITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [NUM_REQ-1:0]                              req_valid,
    input  logic [NUM_REQ-1:0][FRAG_LEN_BITS-1:0]           req_fragment,
    input  logic [NUM_REQ-1:0][INDICES_COUNT-1:0][INDICE_LEN-1:0] req_indices,
    output logic [NUM_REQ-1:0]                              req_ready,
    input  logic                                            abort,
    output logic [FRAG_LEN_BITS-1:0]                        ext_fragment,
    output logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]        ext_indices,
    output logic                                            ext_valid_indices,
    output logic [PART_BITS-1:0]                            ext_part_idx,
    output logic [IDX_BITS-1:0]                             ext_index_idx,
    output logic                                            ext_active,
    output logic                                            ext_last,
    output logic                                            done_valid,
    output logic [REQ_BITS-1:0]                             done_id,
    output logic                                            busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [PART_BITS-1:0] PART_MAX = PART_BITS'(FRAG_PARTS_COUNT - 1);
    localparam logic [IDX_BITS-1:0]  IDX_MAX  = IDX_BITS'(INDICES_COUNT - 1);
    localparam logic                 ONE_PAIR = (FRAG_PARTS_COUNT * INDICES_COUNT == 1);

    state_t                                   state;
    logic [REQ_BITS-1:0]                      last_grant;
    logic [REQ_BITS-1:0]                      job_id;
    logic [REQ_BITS-1:0]                      grant_idx;
    logic [REQ_BITS-1:0]                      cand;
    logic                                     grant_found;
    logic [FRAG_LEN_BITS-1:0]                 frag_q;
    logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] ind_q;
    logic [PART_BITS-1:0]                     part_cnt;
    logic [IDX_BITS-1:0]                      idx_cnt;
    logic [PART_BITS-1:0]                     nxt_part;
    logic [IDX_BITS-1:0]                      nxt_idx;
    logic                                     part_wrap;

    // Search starts just past the previous winner, which is what prevents starvation.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = REQ_BITS'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && grant_found && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        part_wrap = (part_cnt == PART_MAX);
        nxt_part  = part_wrap ? '0 : part_cnt + PART_BITS'(1);
        nxt_idx   = part_wrap ? idx_cnt + IDX_BITS'(1) : idx_cnt;
    end

    assign ext_fragment  = frag_q;
    assign ext_indices   = ind_q;
    assign ext_part_idx  = part_cnt;
    assign ext_index_idx = idx_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            last_grant        <= REQ_BITS'(NUM_REQ - 1);
            job_id            <= '0;
            frag_q            <= '0;
            ind_q             <= '0;
            part_cnt          <= '0;
            idx_cnt           <= '0;
            busy              <= 1'b0;
            ext_valid_indices <= 1'b0;
            ext_active        <= 1'b0;
            ext_last          <= 1'b0;
            done_valid        <= 1'b0;
            done_id           <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        frag_q            <= req_fragment[grant_idx];
                        ind_q             <= req_indices[grant_idx];
                        last_grant        <= grant_idx;
                        job_id            <= grant_idx;
                        busy              <= 1'b1;
                        ext_valid_indices <= 1'b1;
                        state             <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    ext_valid_indices <= 1'b0;
                    part_cnt          <= '0;
                    idx_cnt           <= '0;
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        ext_active <= 1'b1;
                        ext_last   <= ONE_PAIR;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        part_cnt   <= '0;
                        idx_cnt    <= '0;
                        ext_active <= 1'b0;
                        ext_last   <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else if (ext_last) begin
                        part_cnt   <= '0;
                        idx_cnt    <= '0;
                        ext_active <= 1'b0;
                        ext_last   <= 1'b0;
                        done_valid <= 1'b1;
                        done_id    <= job_id;
                        state      <= S_DONE;
                    end else begin
                        // Part is the inner loop; flag the pair that closes the job one cycle ahead.
                        part_cnt <= nxt_part;
                        idx_cnt  <= nxt_idx;
                        ext_last <= (nxt_part == PART_MAX) && (nxt_idx == IDX_MAX);
                    end
                end
                S_DONE: begin
                    done_valid <= 1'b0;
                    done_id    <= '0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proj_extender_sched.sv
// tb/tb_proj_extender_sched.sv - scheduler bench: job-level reference model plus directed scenarios
module tb_proj_extender_sched;

    localparam int NR  = 2;
    localparam int JOB = 8;
    localparam int NP  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]            req_valid = '0;
    logic [1:0][7:0]       req_fragment = '0;
    logic [1:0][3:0][2:0]  req_indices = '0;
    logic                  abort = 1'b0;
    logic [1:0]            req_ready;
    logic [7:0]            ext_fragment;
    logic [3:0][2:0]       ext_indices;
    logic                  ext_valid_indices;
    logic                  ext_part_idx;
    logic [1:0]            ext_index_idx;
    logic                  ext_active;
    logic                  ext_last;
    logic                  done_valid;
    logic                  done_id;
    logic                  busy;

    logic [1:0]            p_req_valid = '0;
    logic [1:0][15:0]      p_req_fragment = '0;
    logic [1:0][1:0][2:0]  p_req_indices = '0;
    logic                  p_abort = 1'b0;
    logic [1:0]            p_req_ready;
    logic [15:0]           p_ext_fragment;
    logic [1:0][2:0]       p_ext_indices;
    logic                  p_ext_valid_indices;
    logic [1:0]            p_ext_part_idx;
    logic                  p_ext_index_idx;
    logic                  p_ext_active;
    logic                  p_ext_last;
    logic                  p_done_valid;
    logic                  p_done_id;
    logic                  p_busy;

    proj_extender_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_fragment(req_fragment),
        .req_indices(req_indices), .req_ready(req_ready), .abort(abort),
        .ext_fragment(ext_fragment), .ext_indices(ext_indices),
        .ext_valid_indices(ext_valid_indices), .ext_part_idx(ext_part_idx),
        .ext_index_idx(ext_index_idx), .ext_active(ext_active), .ext_last(ext_last),
        .done_valid(done_valid), .done_id(done_id), .busy(busy)
    );

    proj_extender_sched #(.FRAG_LEN_BITS(16), .INDICES_COUNT(2)) dut_p (
        .clk(clk), .rst(rst), .req_valid(p_req_valid), .req_fragment(p_req_fragment),
        .req_indices(p_req_indices), .req_ready(p_req_ready), .abort(p_abort),
        .ext_fragment(p_ext_fragment), .ext_indices(p_ext_indices),
        .ext_valid_indices(p_ext_valid_indices), .ext_part_idx(p_ext_part_idx),
        .ext_index_idx(p_ext_index_idx), .ext_active(p_ext_active), .ext_last(p_ext_last),
        .done_valid(p_done_valid), .done_id(p_done_id), .busy(p_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a job is a timeline measured from its accept cycle.
    bit          m_busy = 0;
    int          m_age  = 0;
    int          m_last = NR - 1;
    int          m_id   = 0;
    logic [7:0]  m_frag = '0;
    logic [11:0] m_ind  = '0;
    int          done_log[$];

    always @(negedge clk) begin : model_cmp
        logic [1:0] e_ready;
        logic e_vi, e_act, e_lst, e_done;
        int e_part, e_idx, e_id, g, k;
        bit found;
        e_ready = '0; e_vi = 0; e_act = 0; e_lst = 0; e_done = 0;
        e_part = 0; e_idx = 0; e_id = 0; g = 0; k = 0; found = 0;
        if (rst) begin
            m_busy = 0; m_age = 0; m_last = NR - 1; m_frag = '0; m_ind = '0;
        end else if (!m_busy) begin
            for (int j = 1; j <= NR; j++) begin
                if (!found && req_valid[(m_last + j) % NR]) begin
                    found = 1; g = (m_last + j) % NR;
                end
            end
            if (found) e_ready[g] = 1'b1;
        end else if (m_age == 1) begin
            e_vi = 1;
        end else if (m_age <= JOB + 1) begin
            k = m_age - 2;
            e_act = 1; e_part = k % NP; e_idx = k / NP; e_lst = (k == JOB - 1);
        end else begin
            e_done = 1; e_id = m_id;
        end
        check("req_ready", req_ready, e_ready);
        check("busy", busy, m_busy);
        check("ext_valid_indices", ext_valid_indices, e_vi);
        check("ext_active", ext_active, e_act);
        check("ext_last", ext_last, e_lst);
        check("ext_part_idx", ext_part_idx, e_part);
        check("ext_index_idx", ext_index_idx, e_idx);
        check("done_valid", done_valid, e_done);
        check("done_id", done_id, e_id);
        check("ext_fragment", ext_fragment, m_frag);
        check("ext_indices", ext_indices, m_ind);
        if (done_valid) done_log.push_back(int'(done_id));
        if (!rst) begin
            if (!m_busy) begin
                if (found) begin
                    m_busy = 1; m_age = 1; m_last = g; m_id = g;
                    m_frag = req_fragment[g]; m_ind = req_indices[g];
                end
            end else if (abort && m_age <= JOB + 1) begin
                m_busy = 0;
            end else if (m_age == JOB + 2) begin
                m_busy = 0;
            end else begin
                m_age++;
            end
        end
    end

    task automatic wait_ready(output logic [1:0] rdy, output int at);
        int n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 60) begin
            @(negedge clk);
            n++;
        end
        rdy = req_ready;
        at  = cyc;
        if (req_ready == 2'b00) begin
            checks++; errors++;
            $display("FAIL wait_ready: got no grant expected a grant within 60 cycles");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL wait_idle: got busy=1 expected 0 within 60 cycles");
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        int exp_idx[8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
        int exp_part[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        int p_idx[8]    = '{0, 0, 0, 0, 1, 1, 1, 1};
        int p_part[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [1:0] r0, r1, r2;
        int t0, t1, t2, n, runs;

        // Reset state, with requests already pending
        req_valid = 2'b11;
        @(negedge clk);
        check("rst_ready", req_ready, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_frag", ext_fragment, 8'h00);
        check("rst_done", done_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 2'b01;
        req_fragment[0] = 8'hB4;
        req_indices[0]  = {3'd3, 3'd1, 3'd6, 3'd2};

        // Single job timeline
        wait_ready(r0, t0);
        check("t1_ready", r0, 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        check("t1_load", ext_valid_indices, 1'b1);
        check("t1_frag", ext_fragment, 8'hB4);
        check("t1_ind", ext_indices, 12'h672);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t1_active", ext_active, 1'b1);
            check("t1_idx", ext_index_idx, exp_idx[k]);
            check("t1_part", ext_part_idx, exp_part[k]);
            check("t1_last", ext_last, k == 7);
        end
        @(negedge clk);
        check("t1_done", done_valid, 1'b1);
        check("t1_done_id", done_id, 1'b0);
        @(negedge clk);
        check("t1_idle", busy, 1'b0);

        // Contention: grants alternate, one accept every 11 cycles
        do_reset();
        done_log.delete();
        req_valid = 2'b11;
        wait_ready(r0, t0);
        @(posedge clk); #1;
        wait_ready(r1, t1);
        @(posedge clk); #1;
        wait_ready(r2, t2);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_idle();
        check("c_grant0", r0, 2'b01);
        check("c_grant1", r1, 2'b10);
        check("c_grant2", r2, 2'b01);
        check("c_gap1", t1 - t0, 11);
        check("c_gap2", t2 - t1, 11);
        check("c_done_cnt", done_log.size(), 3);
        if (done_log.size() == 3) begin
            check("c_done_ids", {done_log[0][1:0], done_log[1][1:0], done_log[2][1:0]}, 6'b00_01_00);
        end

        // Round robin after reset
        do_reset();
        req_valid = 2'b10;
        wait_ready(r0, t0);
        check("rr_first", r0, 2'b10);
        @(posedge clk); #1 req_valid = 2'b11;
        wait_ready(r1, t1);
        check("rr_second", r1, 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_idle();

        // Abort on the 4th RUN cycle with req1 pending
        req_valid = 2'b01;
        wait_ready(r0, t0);
        @(posedge clk); #1 req_valid = 2'b10;
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        check("ab_active", ext_active, 1'b1);
        check("ab_pair", {ext_index_idx, ext_part_idx}, {2'd1, 1'b1});
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("ab_busy", busy, 1'b0);
        check("ab_nodone", done_valid, 1'b0);
        check("ab_next", req_ready, 2'b10);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_idle();

        // Asynchronous reset mid-RUN
        req_valid = 2'b01;
        wait_ready(r0, t0);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("ar_busy", busy, 1'b0);
        check("ar_active", ext_active, 1'b0);
        check("ar_vi", ext_valid_indices, 1'b0);
        @(posedge clk); #2 rst = 1'b0;
        req_valid = 2'b11;
        wait_ready(r0, t0);
        check("ar_grant", r0, 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_idle();

        // Randomized traffic with abort and reset pulses; checked by the model
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            req_valid = 2'($urandom_range(0, 3));
            for (int r = 0; r < NR; r++) begin
                req_fragment[r] = 8'($urandom);
                req_indices[r]  = 12'($urandom);
            end
            abort = ($urandom_range(0, 19) == 0);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 2'b00; abort = 1'b0;
        wait_idle();

        // Wider fragment, fewer indices
        p_req_valid = 2'b01;
        p_req_fragment[0] = 16'hC35A;
        p_req_indices[0]  = {3'd5, 3'd2};
        n = 0;
        @(negedge clk);
        while (p_req_ready == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("p_ready", p_req_ready, 2'b01);
        @(posedge clk); #1 p_req_valid = 2'b00;
        @(negedge clk);
        check("p_load", p_ext_valid_indices, 1'b1);
        check("p_frag", p_ext_fragment, 16'hC35A);
        check("p_ind", p_ext_indices, 6'o52);
        runs = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (p_ext_active) runs++;
            check("p_idx", p_ext_index_idx, p_idx[k]);
            check("p_part", p_ext_part_idx, p_part[k]);
            check("p_last", p_ext_last, k == 7);
        end
        @(negedge clk);
        check("p_runs", runs, 8);
        check("p_done", p_done_valid, 1'b1);
        check("p_done_id", p_done_id, 1'b0);
        @(negedge clk);
        check("p_idle", p_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proj_extender_sched.md
Name: proj_extender_sched

Overview:
- Round-robin scheduler that shares one fragment-extender datapath between NUM_REQ requesters.
- Each job is one fragment plus its set of k-mer indices. The block grants one requester, latches that job, then loads the extender.
- It then sequences the extender through every (index, fragment-part) pair, one pair per clock, and reports completion per requester.
- Sits between the upstream fragment/index producers and the extender plus downstream GFM consumer.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- FRAG_LEN_BITS, 8, fragment width in bits.
- FRAG_PART, 4, bits per fragment part; FRAG_LEN_BITS is a multiple of FRAG_PART.
- INDICES_COUNT, 4, k-mer indices per job (power of 2).
- INDICE_LEN, 3, width of one index.
- Derived: FRAG_PARTS_COUNT = FRAG_LEN_BITS/FRAG_PART (2 by default). PART_BITS = max(1, clog2(FRAG_PARTS_COUNT)). IDX_BITS = max(1, clog2(INDICES_COUNT)). REQ_BITS = max(1, clog2(NUM_REQ)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- req_valid  in  NUM_REQ  per-requester job offer.
- req_fragment  in  NUM_REQ x FRAG_LEN_BITS  per-requester fragment.
- req_indices  in  NUM_REQ x INDICES_COUNT x INDICE_LEN  per-requester index set.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- abort  in  1  cancel current job.
- ext_fragment  out  FRAG_LEN_BITS  latched fragment to extender.
- ext_indices  out  INDICES_COUNT x INDICE_LEN  latched indices to extender.
- ext_valid_indices  out  1  extender index-load strobe.
- ext_part_idx  out  PART_BITS  current fragment part.
- ext_index_idx  out  IDX_BITS  current index slot.
- ext_active  out  1  (part, index) pair valid this cycle.
- ext_last  out  1  final pair of job.
- done_valid  out  1  job-complete pulse.
- done_id  out  REQ_BITS  requester of completed job.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, LOAD, RUN, DONE. All flops are async-reset on rst high.
- Reset values: state=IDLE. All outputs 0. Latched fragment/indices = 0. last_grant = NUM_REQ-1, so requester 0 wins first.
- IDLE:
  - If any req_valid, grant the first requester searching from last_grant+1 (mod NUM_REQ).
  - Combinationally raise req_ready[g] this cycle only. The handshake completes when valid and ready are both high.
  - On the clock edge: latch req_fragment[g] and req_indices[g], set last_grant=g, store job_id=g, go to LOAD.
  - If no req_valid, stay in IDLE with req_ready=0.
- LOAD:
  - ext_valid_indices=1 for exactly this cycle. ext_fragment/ext_indices are already stable.
  - Clear part_cnt and idx_cnt. Go to RUN.
- RUN:
  - ext_active=1. ext_part_idx=part_cnt, ext_index_idx=idx_cnt.
  - Each cycle part_cnt increments. At FRAG_PARTS_COUNT-1 it wraps to 0 and idx_cnt increments. Part is the inner loop, index the outer loop.
  - ext_last=1 when part_cnt=FRAG_PARTS_COUNT-1 and idx_cnt=INDICES_COUNT-1. Next state is DONE.
- DONE: done_valid=1, done_id=job_id for one cycle, then IDLE.
- Latency:
  - Accept in cycle T, ext_valid_indices in T+1.
  - RUN spans T+2 .. T+1+INDICES_COUNT*FRAG_PARTS_COUNT.
  - done_valid follows one cycle after the ext_last cycle.
  - Next accept is possible one cycle after DONE (back-to-back period = JOB_LEN+3).
- abort:
  - Sampled in LOAD or RUN: next state IDLE. No done_valid. Counters cleared. last_grant is kept, so rotation still advances.
  - Ignored in IDLE and DONE.
- req_ready is never asserted outside IDLE. Changes to req_* while busy have no effect on latched data.
- Simultaneous requests are resolved by the round-robin pointer only. Nothing is starved: a requester that keeps its valid high is granted within NUM_REQ jobs.
- rst asserted mid-job: immediate return to reset values, with no done pulse.

Test Plan:
- Single job, default params. req_valid=01, frag=8'hB4, indices={3,1,6,2}. Required response:
  - req_ready=01 at T; ext_valid_indices=1 at T+1.
  - RUN T+2..T+9 with (idx,part) sequence (0,0),(0,1),(1,0),(1,1)...(3,1); ext_last at T+9.
  - done_valid with done_id=0 at T+10.
- Contention: req_valid=11 held across three jobs -> grants in order 0,1,0; done_id sequence 0,1,0; accepts 11 cycles apart.
- Round-robin after reset: only req1 valid -> granted. Then both valid -> req0 granted next.
- Abort at the 4th RUN cycle -> IDLE next cycle, no done_valid, busy=0. A pending req is accepted the following cycle.
- Async rst pulse mid-RUN, asserted between clock edges -> busy, ext_active and ext_valid_indices go to 0 immediately. After release the first grant goes to req0.
- Param sweep FRAG_LEN_BITS=16, INDICES_COUNT=2 -> 8 RUN cycles; part wraps at 3 and index at 1.
